// File: rtl/mips_pkg.sv
// Shared MEM-stage definitions: access-size encodings, register index width
// and the MEM/WB pipeline record with its bubble value.
package mips_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } mem_size_e;

  // rd_en/size/zext/offset travel with the record so lane selection can be
  // applied to the RAM's registered read word one cycle later.
  typedef struct packed {
    logic             reg_write;
    logic             mem_to_reg;
    logic [REG_W-1:0] write_reg;
    logic [31:0]      ex_data;
    logic             misaligned;
    logic             rd_en;
    mem_size_e        size;
    logic             zext;
    logic [1:0]       offset;
  } memwb_t;

  localparam memwb_t MEMWB_BUBBLE = '{
    reg_write:  1'b0,
    mem_to_reg: 1'b0,
    write_reg:  '0,
    ex_data:    '0,
    misaligned: 1'b0,
    rd_en:      1'b0,
    size:       SIZE_BYTE,
    zext:       1'b0,
    offset:     2'b00
  };

endpackage

// File: rtl/data_ram.sv
// Single-port data RAM with byte enables; the read returns the word as it
// was before any write on the same edge.
module data_ram #(
  parameter int MEM_WORDS = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    rdata_q <= mem_q[addr];
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/memory_access.sv
// MEM pipeline stage: byte/half/word loads and stores against data_ram with
// alignment checking, stall/flush handling and registered MEM/WB outputs.
module memory_access
  import mips_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int ADDR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             MemToReg_in,
  input  logic             RegWrite_in,
  input  logic [1:0]       mem_size,
  input  logic             mem_unsigned,
  input  logic [31:0]      alu_result,
  input  logic [31:0]      write_data,
  input  logic [REG_W-1:0] write_reg_in,
  output logic [31:0]      mem_data,
  output logic [31:0]      ex_data,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic [REG_W-1:0] write_reg,
  output logic             misaligned
);

  memwb_t      wb_q, wb_d;
  logic        hold_q, hold_d;
  logic [31:0] mem_hold_q, mem_hold_d;
  mem_size_e   size;
  logic        misal, bad_access, store_en;
  logic [3:0]  lane_be, ram_be;
  logic [31:0] ram_wdata, ram_rdata, shifted, load_val;

  assign size       = mem_size_e'(mem_size);
  assign bad_access = (MemRead | MemWrite) & misal;
  assign store_en   = MemWrite & ~misal & ~stall & ~flush & ~reset;
  assign ram_be     = store_en ? lane_be : 4'b0000;

  always_comb begin
    misal     = 1'b0;
    lane_be   = 4'b1111;
    ram_wdata = write_data;
    unique case (size)
      SIZE_BYTE: begin
        lane_be   = 4'b0001 << alu_result[1:0];
        ram_wdata = {4{write_data[7:0]}};
      end
      SIZE_HALF: begin
        misal     = alu_result[0];
        lane_be   = alu_result[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{write_data[15:0]}};
      end
      default: misal = |alu_result[1:0];
    endcase
  end

  data_ram #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .be    (ram_be),
    .addr  (alu_result[ADDR_W+1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Half accesses are aligned here, so offset[1] alone picks the half.
  assign shifted = ram_rdata >> {wb_q.offset, 3'b000};

  always_comb begin
    load_val = '0;
    if (wb_q.rd_en) begin
      unique case (wb_q.size)
        SIZE_BYTE: load_val = wb_q.zext ? {24'b0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
        SIZE_HALF: load_val = wb_q.zext ? {16'b0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
        default:   load_val = ram_rdata;
      endcase
    end
  end

  // The RAM re-reads every cycle, so a stalled load result is parked in mem_hold_q.
  assign mem_data = hold_q ? mem_hold_q : load_val;

  always_comb begin
    wb_d       = wb_q;
    hold_d     = hold_q;
    mem_hold_d = mem_hold_q;
    if (flush) begin
      wb_d       = MEMWB_BUBBLE;
      hold_d     = 1'b0;
      mem_hold_d = '0;
    end else if (stall) begin
      wb_d.misaligned = 1'b0;
      hold_d          = 1'b1;
      mem_hold_d      = mem_data;
    end else begin
      wb_d.reg_write  = RegWrite_in & ~bad_access;
      wb_d.mem_to_reg = MemToReg_in;
      wb_d.write_reg  = write_reg_in;
      wb_d.ex_data    = alu_result;
      wb_d.misaligned = bad_access;
      wb_d.rd_en      = MemRead & ~misal;
      wb_d.size       = size;
      wb_d.zext       = mem_unsigned;
      wb_d.offset     = alu_result[1:0];
      hold_d          = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_q       <= MEMWB_BUBBLE;
      hold_q     <= 1'b0;
      mem_hold_q <= '0;
    end else begin
      wb_q       <= wb_d;
      hold_q     <= hold_d;
      mem_hold_q <= mem_hold_d;
    end
  end

  assign ex_data    = wb_q.ex_data;
  assign MemToReg   = wb_q.mem_to_reg;
  assign RegWrite   = wb_q.reg_write;
  assign write_reg  = wb_q.write_reg;
  assign misaligned = wb_q.misaligned;

endmodule

// File: tb/tb_memory_access.sv
// Directed vectors for memory_access; expectations go into a queue and a
// negedge monitor pops one per cycle and compares it with the outputs.
module tb_memory_access;

  localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, SR = 2'b11;

  logic        clk = 1'b0;
  logic        reset, stall, flush, MemRead, MemWrite, MemToReg_in, RegWrite_in;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] alu_result, write_data;
  logic [4:0]  write_reg_in;
  logic [31:0] mem_data, ex_data;
  logic        MemToReg, RegWrite, misaligned;
  logic [4:0]  write_reg;

  always #5 clk = ~clk;

  memory_access #(.MEM_WORDS(256), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg_in(MemToReg_in),
    .RegWrite_in(RegWrite_in), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .alu_result(alu_result), .write_data(write_data), .write_reg_in(write_reg_in),
    .mem_data(mem_data), .ex_data(ex_data), .MemToReg(MemToReg),
    .RegWrite(RegWrite), .write_reg(write_reg), .misaligned(misaligned)
  );

  typedef struct {
    string       name;
    logic [31:0] mem;
    logic [31:0] ex;
    logic        m2r;
    logic        rw;
    logic [4:0]  wreg;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (mem_data !== e.mem || ex_data !== e.ex || MemToReg !== e.m2r ||
          RegWrite !== e.rw || write_reg !== e.wreg || misaligned !== e.mis) begin
        n_bad++;
        $display("FAIL %s: got mem=%h ex=%h m2r=%b rw=%b wreg=%0d mis=%b, need mem=%h ex=%h m2r=%b rw=%b wreg=%0d mis=%b",
                 e.name, mem_data, ex_data, MemToReg, RegWrite, write_reg, misaligned,
                 e.mem, e.ex, e.m2r, e.rw, e.wreg, e.mis);
      end
    end
  end

  task automatic acc(input logic rd, wr, rw, m2r, input logic [1:0] sz,
                     input logic un, input logic [31:0] a, wd, input logic [4:0] wrg);
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    MemRead = rd; MemWrite = wr; RegWrite_in = rw; MemToReg_in = m2r;
    mem_size = sz; mem_unsigned = un; alu_result = a; write_data = wd;
    write_reg_in = wrg;
  endtask

  task automatic ctl(input logic rs, st, fl);
    reset = rs; stall = st; flush = fl;
  endtask

  task automatic chk(input string nm, input logic [31:0] m, x, input logic m2r, rw,
                     input logic [4:0] wrg, input logic ms);
    exp_t e;
    e.name = nm; e.mem = m; e.ex = x; e.m2r = m2r; e.rw = rw; e.wreg = wrg; e.mis = ms;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    acc(1, 1, 1, 1, SW, 0, 32'h44, 32'h12345678, 3); ctl(1, 1, 1);
    chk("reset0", 0, 0, 0, 0, 0, 0);

    acc(0, 1, 0, 0, SW, 0, 32'h10, 32'hDEADBEEF, 0); chk("st_w10", 0, 32'h10, 0, 0, 0, 0);
    acc(1, 0, 1, 0, SW, 0, 32'h10, 0, 5);  chk("lw10", 32'hDEADBEEF, 32'h10, 0, 1, 5, 0);
    acc(1, 0, 1, 0, SB, 0, 32'h13, 0, 6);  chk("lb13", 32'hFFFFFFDE, 32'h13, 0, 1, 6, 0);
    acc(1, 0, 1, 0, SB, 1, 32'h13, 0, 6);  chk("lbu13", 32'h000000DE, 32'h13, 0, 1, 6, 0);
    acc(1, 0, 1, 0, SH, 0, 32'h12, 0, 7);  chk("lh12", 32'hFFFFDEAD, 32'h12, 0, 1, 7, 0);
    acc(1, 0, 1, 0, SH, 1, 32'h10, 0, 7);  chk("lhu10", 32'h0000BEEF, 32'h10, 0, 1, 7, 0);
    acc(1, 0, 1, 0, SB, 0, 32'h10, 0, 7);  chk("lb10", 32'hFFFFFFEF, 32'h10, 0, 1, 7, 0);
    acc(1, 0, 1, 0, SB, 1, 32'h11, 0, 7);  chk("lbu11", 32'h000000BE, 32'h11, 0, 1, 7, 0);

    acc(1, 0, 1, 0, SW, 0, 32'h11, 0, 8);  chk("lw11_mis", 0, 32'h11, 0, 0, 8, 1);
    acc(0, 0, 0, 0, SW, 0, 0, 0, 0);       chk("mis_clear", 0, 0, 0, 0, 0, 0);
    acc(0, 1, 0, 0, SH, 0, 32'h11, 32'h1234, 0); chk("sh11_mis", 0, 32'h11, 0, 0, 0, 1);
    acc(1, 0, 1, 0, SW, 0, 32'h10, 0, 5);  chk("lw10_intact", 32'hDEADBEEF, 32'h10, 0, 1, 5, 0);

    acc(0, 1, 0, 0, SB, 0, 32'h12, 32'hFFFFFFAA, 0); chk("sb12", 0, 32'h12, 0, 0, 0, 0);
    acc(1, 0, 1, 0, SW, 0, 32'h10, 0, 5);  chk("lw10_fwd", 32'hDEAABEEF, 32'h10, 0, 1, 5, 0);
    acc(0, 1, 0, 0, SH, 0, 32'h10, 32'h55667788, 0); chk("sh10", 0, 32'h10, 0, 0, 0, 0);
    acc(1, 1, 1, 0, SW, 0, 32'h10, 32'hCAFEF00D, 9); chk("rbw", 32'hDEAA7788, 32'h10, 0, 1, 9, 0);
    acc(1, 0, 1, 1, SW, 0, 32'h10, 0, 10); chk("lw10_m2r", 32'hCAFEF00D, 32'h10, 1, 1, 10, 0);

    for (int i = 0; i < 3; i++) begin
      acc(1, 1, 1, 0, SW, 0, (i == 1) ? 32'h17 : 32'h10, 32'h0BADF00D, 11); ctl(0, 1, 0);
      chk("stall", 32'hCAFEF00D, 32'h10, 1, 1, 10, 0);
    end
    acc(1, 1, 1, 1, SW, 0, 32'h10, 32'h0BADF00D, 11); ctl(0, 1, 1);
    chk("flush_stall", 0, 0, 0, 0, 0, 0);
    acc(1, 0, 1, 0, SW, 0, 32'h10, 0, 12); chk("lw10_post_stall", 32'hCAFEF00D, 32'h10, 0, 1, 12, 0);
    acc(1, 0, 1, 1, SW, 0, 32'h10, 0, 13); ctl(0, 0, 1);
    chk("flush", 0, 0, 0, 0, 0, 0);

    acc(0, 1, 0, 0, SW, 0, 32'h400, 32'h13579BDF, 0); chk("st_w400", 0, 32'h400, 0, 0, 0, 0);
    acc(1, 0, 1, 0, SW, 0, 32'h0, 0, 14);  chk("lw0_wrap", 32'h13579BDF, 0, 0, 1, 14, 0);
    acc(1, 0, 1, 0, SR, 1, 32'h0, 0, 15);  chk("lw0_rsvd", 32'h13579BDF, 0, 0, 1, 15, 0);
    acc(1, 0, 1, 0, SR, 0, 32'h2, 0, 16);  chk("rsvd_mis", 0, 32'h2, 0, 0, 16, 1);

    acc(1, 1, 1, 1, SW, 0, 32'h0, 32'hFFFFFFFF, 17); ctl(1, 0, 0);
    chk("reset_mid", 0, 0, 0, 0, 0, 0);
    acc(1, 0, 1, 0, SW, 0, 32'h0, 0, 18);  chk("lw0_post_rst", 32'h13579BDF, 0, 0, 1, 18, 0);
    acc(0, 0, 0, 0, SW, 0, 0, 0, 0);       chk("final_idle", 0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, need 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 256, giving the data memory depth in 32-bit words (power of two).
REQ-002 The block SHALL have parameter ADDR_W, default 8, equal to log2(MEM_WORDS).
REQ-003 Ports SHALL be as follows, one clock and a synchronous active-high reset:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold the MEM/WB outputs
- flush  in  1  insert a bubble
- MemRead  in  1  load request
- MemWrite  in  1  store request
- MemToReg_in  in  1  writeback select: 0 = memory data, 1 = ex data
- RegWrite_in  in  1  register write enable
- mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- mem_unsigned  in  1  zero-extend loads when 1
- alu_result  in  32  byte address, also the ex-path data
- write_data  in  32  store data, right-aligned
- write_reg_in  in  5  destination register
- mem_data  out  32  registered load result
- ex_data  out  32  registered alu_result
- MemToReg  out  1  registered MemToReg_in
- RegWrite  out  1  registered, qualified RegWrite_in
- write_reg  out  5  registered write_reg_in
- misaligned  out  1  one-cycle fault flag

Function
REQ-004 All outputs SHALL be registered, with a latency of exactly 1 clock from the inputs to the outputs.
REQ-005 The word index SHALL be alu_result[ADDR_W+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo MEM_WORDS*4.
REQ-006 Byte lanes SHALL be little-endian: byte n occupies bits [8n+7:8n].
REQ-007 Stores SHALL write only the addressed lanes on the rising edge: byte writes write_data[7:0], half writes write_data[15:0] to lanes {2a+1, 2a}, word writes all lanes.
REQ-008 Loads SHALL select the addressed byte/half/word and then sign-extend, or zero-extend when mem_unsigned=1; word loads ignore mem_unsigned.
REQ-009 When MemRead=0, mem_data SHALL load 0.
REQ-010 An access is misaligned when:
- a half access has alu_result[0]=1, or
- a word access has alu_result[1:0]≠0.
REQ-011 On a misaligned access with MemRead or MemWrite set, the block SHALL:
- suppress the store,
- load mem_data=0,
- force RegWrite=0,
- pulse misaligned=1 for one cycle.
REQ-012 When MemRead and MemWrite are both 1, the block SHALL perform the store and return the pre-write contents on mem_data (read-before-write).
REQ-013 When stall=1 and flush=0, all outputs SHALL hold their values, the store SHALL be suppressed, and misaligned SHALL be 0.
REQ-014 When flush=1, regardless of stall, the block SHALL suppress the store and load a bubble: RegWrite=0, MemToReg=0, write_reg=0, mem_data=0, ex_data=0, misaligned=0.
REQ-015 A load to the same word as a store in the immediately preceding cycle SHALL return the newly stored data.
REQ-016 ex_data SHALL equal the registered alu_result; write_reg and MemToReg SHALL pass through unmodified, subject only to REQ-013 and REQ-014.

Reset
REQ-017 When reset=1 at a rising edge, all outputs SHALL become 0 and any store SHALL be suppressed; reset has priority over flush and stall.
REQ-018 Memory contents SHALL NOT be cleared by reset; contents after power-up are undefined to the bench, which SHALL initialise memory through stores.

Structure
REQ-019 Shared package mips_pkg SHALL hold:
- the mem_size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD,
- the MEM/WB bubble constant,
- the register-index width (5).
REQ-020 Storage SHALL be a single sub-module data_ram with:
- parameters MEM_WORDS and ADDR_W,
- ports clk, a 4-bit byte enable, addr, wdata and rdata,
- one synchronous read-before-write port.
REQ-021 Lane and extension logic SHALL be combinational in memory_access, with no other sub-modules.

Verification
REQ-022 Store word 0xDEADBEEF at 0x10, then load word at 0x10 -> mem_data=0xDEADBEEF one cycle later, RegWrite=1.
REQ-023 Byte loads, signed and unsigned, at 0x13 after REQ-022 -> signed gives 0xFFFFFFDE, unsigned gives 0x000000DE; signed half at 0x12 -> 0xFFFFDEAD.
REQ-024 Word load at 0x11 with RegWrite_in=1 -> mem_data=0, RegWrite=0, misaligned=1 for one cycle; a half store at 0x11 leaves memory unchanged.
REQ-025 Stall for 3 cycles during a store -> outputs frozen and memory unchanged; then flush=1 with stall=1 -> bubble outputs and store suppressed.
REQ-026 Store at 0x400 with MEM_WORDS=256 -> a load from 0x000 returns the stored word (wrap-around).
REQ-027 Assert reset mid-stream with a pending store -> all outputs 0 next cycle, store not performed, and earlier memory contents intact.
